// File: rtl/retire_wide_pkg.sv
// retire_wide_pkg: shared types for the wide-retire reorder buffer.
//   t_prf_id          physical register id (reclaimed at retire)
//   t_paddr           fetch/redirect address
//   t_rob_wide_entry  per-entry ROB state
package retire_wide_pkg;

  typedef logic [6:0]  t_prf_id;
  typedef logic [31:0] t_paddr;

  typedef struct packed {
    logic    valid;
    logic    complete;
    logic    has_dst;
    t_prf_id old_pdst;
    logic    mispred;
    t_paddr  tgt;
  } t_rob_wide_entry;

endpackage

// File: rtl/retire_wide_if.sv
// retire_wide_if: bundle of rename/execute-side signals of the wide-retire ROB.
//   master: rename + execute + free list / fetch (drives alloc and completion)
//   slave : the ROB (drives ready, tail id, reclaim, redirect, empty)
interface retire_wide_if import retire_wide_pkg::*; #(
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned RETIRE_WIDTH = 2,
  parameter int unsigned IDX_W        = $clog2(DEPTH),
  parameter int unsigned CNT_W        = $clog2(RETIRE_WIDTH + 1)
);

  // Rename (ra0)
  logic                              rob_ready_ra0;
  logic                              alloc_ra0;
  logic                              alloc_has_dst_ra0;
  t_prf_id                           alloc_old_pdst_ra0;
  logic [IDX_W-1:0]                  next_robid_ra0;
  // Completion (rb0)
  logic                              ro_valid_rb0;
  logic [IDX_W-1:0]                  ro_robid_rb0;
  logic                              ro_mispred_rb0;
  t_paddr                            ro_tgt_rb0;
  // Retire results (rb1)
  logic [RETIRE_WIDTH-1:0]           reclaim_prf_rb1;
  t_prf_id [RETIRE_WIDTH-1:0]        reclaim_prf_id_rb1;
  logic [CNT_W-1:0]                  retire_cnt_rb1;
  logic                              br_mispred_rb1;
  t_paddr                            br_tgt_rb1;
  logic                              rob_empty;

  modport master (
    input  rob_ready_ra0, next_robid_ra0, reclaim_prf_rb1, reclaim_prf_id_rb1,
           retire_cnt_rb1, br_mispred_rb1, br_tgt_rb1, rob_empty,
    output alloc_ra0, alloc_has_dst_ra0, alloc_old_pdst_ra0, ro_valid_rb0,
           ro_robid_rb0, ro_mispred_rb0, ro_tgt_rb0
  );

  modport slave (
    output rob_ready_ra0, next_robid_ra0, reclaim_prf_rb1, reclaim_prf_id_rb1,
           retire_cnt_rb1, br_mispred_rb1, br_tgt_rb1, rob_empty,
    input  alloc_ra0, alloc_has_dst_ra0, alloc_old_pdst_ra0, ro_valid_rb0,
           ro_robid_rb0, ro_mispred_rb0, ro_tgt_rb0
  );

endinterface

// File: rtl/retire_wide_rob_retire_sel.sv
// rob_retire_sel: combinational in-order prefix selector over the head window.
//   win_valid_i/win_complete_i/win_mispred_i : state of entries head+0..head+RW-1
//   retire_mask_o  : per-slot retire decision
//   retire_cnt_o   : number of slots retiring
//   mispred_o      : retiring group ends with a mispredicted branch
//   mispred_slot_o : slot holding that branch
module rob_retire_sel #(
  parameter int unsigned RETIRE_WIDTH = 2,
  parameter int unsigned CNT_W        = $clog2(RETIRE_WIDTH + 1),
  parameter int unsigned SLOT_W       = (RETIRE_WIDTH > 1) ? $clog2(RETIRE_WIDTH) : 1
) (
  input  logic [RETIRE_WIDTH-1:0] win_valid_i,
  input  logic [RETIRE_WIDTH-1:0] win_complete_i,
  input  logic [RETIRE_WIDTH-1:0] win_mispred_i,
  output logic [RETIRE_WIDTH-1:0] retire_mask_o,
  output logic [CNT_W-1:0]        retire_cnt_o,
  output logic                    mispred_o,
  output logic [SLOT_W-1:0]       mispred_slot_o
);

  logic grp_open;

  // A slot retires only while every lower slot retired and none was a
  // mispredict; the first blocker closes the group.
  always_comb begin
    retire_mask_o  = '0;
    retire_cnt_o   = '0;
    mispred_o      = 1'b0;
    mispred_slot_o = '0;
    grp_open       = 1'b1;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      if (grp_open && win_valid_i[k] && win_complete_i[k]) begin
        retire_mask_o[k] = 1'b1;
        retire_cnt_o     = retire_cnt_o + CNT_W'(1);
        if (win_mispred_i[k]) begin
          mispred_o      = 1'b1;
          mispred_slot_o = SLOT_W'(k);
          grp_open       = 1'b0;
        end
      end else begin
        grp_open = 1'b0;
      end
    end
  end

endmodule

// File: rtl/retire_wide.sv
// retire_wide: DEPTH-entry reorder buffer with up to RETIRE_WIDTH in-order
// retirements per cycle, stale-PRF reclaim and mispredict redirect + flush.
//   clk, reset : core clock, asynchronous active-high reset
//   rob_if     : slave side of retire_wide_if (alloc, completion, rb1 results)
//   ASSERT_EN  : enables protocol checks on illegal alloc / completion
module retire_wide import retire_wide_pkg::*; #(
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned RETIRE_WIDTH = 2,
  parameter bit          ASSERT_EN    = 1'b1
) (
  input logic          clk,
  input logic          reset,
  retire_wide_if.slave rob_if
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned CNT_W  = $clog2(RETIRE_WIDTH + 1);
  localparam int unsigned SLOT_W = (RETIRE_WIDTH > 1) ? $clog2(RETIRE_WIDTH) : 1;

  t_rob_wide_entry entry_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q, head_d, tail_d, count;
  logic             full, empty;

  // Head window
  logic [IDX_W-1:0]        win_idx [RETIRE_WIDTH];
  t_rob_wide_entry         win_ent [RETIRE_WIDTH];
  logic [RETIRE_WIDTH-1:0] win_valid, win_complete, win_mispred;

  logic [RETIRE_WIDTH-1:0] sel_mask;
  logic [CNT_W-1:0]        sel_cnt;
  logic                    sel_mispred;
  logic [SLOT_W-1:0]       sel_slot;

  logic flush, alloc_ok, comp_ok;

  // rb1 output flops
  logic [RETIRE_WIDTH-1:0]    reclaim_q, reclaim_d;
  t_prf_id [RETIRE_WIDTH-1:0] reclaim_id_q, reclaim_id_d;
  logic [CNT_W-1:0]           retire_cnt_q;
  logic                       br_mispred_q;
  t_paddr                     br_tgt_q, br_tgt_d;

  // Occupancy uses the wrap bit so full and empty are distinguishable.
  assign count = tail_q - head_q;
  assign full  = (count == PTR_W'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      win_idx[k]      = head_q[IDX_W-1:0] + IDX_W'(k);
      win_ent[k]      = entry_q[win_idx[k]];
      win_valid[k]    = win_ent[k].valid;
      win_complete[k] = win_ent[k].complete;
      win_mispred[k]  = win_ent[k].mispred;
    end
  end

  rob_retire_sel #(
    .RETIRE_WIDTH (RETIRE_WIDTH),
    .CNT_W        (CNT_W),
    .SLOT_W       (SLOT_W)
  ) u_sel (
    .win_valid_i    (win_valid),
    .win_complete_i (win_complete),
    .win_mispred_i  (win_mispred),
    .retire_mask_o  (sel_mask),
    .retire_cnt_o   (sel_cnt),
    .mispred_o      (sel_mispred),
    .mispred_slot_o (sel_slot)
  );

  // A mispredict in the retiring group flushes everything younger and
  // overrides any same-cycle alloc or completion.
  assign flush    = sel_mispred;
  assign alloc_ok = rob_if.alloc_ra0 && !full && !flush;
  assign comp_ok  = rob_if.ro_valid_rb0 && !flush &&
                    entry_q[rob_if.ro_robid_rb0].valid &&
                    !entry_q[rob_if.ro_robid_rb0].complete;

  always_comb begin
    head_d = head_q + PTR_W'(sel_cnt);
    if (flush) begin
      tail_d = head_d;
    end else begin
      tail_d = tail_q + PTR_W'(alloc_ok);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i].valid <= 1'b0;
      end
    end else begin
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
        if (sel_mask[k]) begin
          entry_q[win_idx[k]].valid <= 1'b0;
        end
      end
      // The tail slot is never in the retiring window unless full, and alloc
      // is blocked when full, so these writes never collide.
      if (alloc_ok) begin
        entry_q[tail_q[IDX_W-1:0]] <= '{valid:    1'b1,
                                       complete: 1'b0,
                                       has_dst:  rob_if.alloc_has_dst_ra0,
                                       old_pdst: rob_if.alloc_old_pdst_ra0,
                                       mispred:  1'b0,
                                       tgt:      '0};
      end
      if (comp_ok) begin
        entry_q[rob_if.ro_robid_rb0].complete <= 1'b1;
        entry_q[rob_if.ro_robid_rb0].mispred  <= rob_if.ro_mispred_rb0;
        entry_q[rob_if.ro_robid_rb0].tgt      <= rob_if.ro_tgt_rb0;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      reclaim_d[k]    = sel_mask[k] && win_ent[k].has_dst;
      reclaim_id_d[k] = reclaim_d[k] ? win_ent[k].old_pdst : '0;
    end
    br_tgt_d = flush ? win_ent[sel_slot].tgt : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reclaim_q    <= '0;
      reclaim_id_q <= '0;
      retire_cnt_q <= '0;
      br_mispred_q <= 1'b0;
      br_tgt_q     <= '0;
    end else begin
      reclaim_q    <= reclaim_d;
      reclaim_id_q <= reclaim_id_d;
      retire_cnt_q <= sel_cnt;
      br_mispred_q <= flush;
      br_tgt_q     <= br_tgt_d;
    end
  end

  assign rob_if.rob_ready_ra0      = !full;
  assign rob_if.next_robid_ra0     = tail_q[IDX_W-1:0];
  assign rob_if.rob_empty          = empty;
  assign rob_if.reclaim_prf_rb1    = reclaim_q;
  assign rob_if.reclaim_prf_id_rb1 = reclaim_id_q;
  assign rob_if.retire_cnt_rb1     = retire_cnt_q;
  assign rob_if.br_mispred_rb1     = br_mispred_q;
  assign rob_if.br_tgt_rb1         = br_tgt_q;

  if (ASSERT_EN) begin : g_assert
    a_alloc_when_ready : assert property (@(posedge clk) disable iff (reset)
      rob_if.alloc_ra0 |-> !full)
      else $error("retire_wide: alloc while ROB full");
    a_comp_legal : assert property (@(posedge clk) disable iff (reset)
      (rob_if.ro_valid_rb0 && !flush) |->
        (entry_q[rob_if.ro_robid_rb0].valid && !entry_q[rob_if.ro_robid_rb0].complete))
      else $error("retire_wide: completion to invalid or complete entry");
  end

endmodule
